// File: rtl/rs232_rx.sv
// rs232_rx: 16x-oversampling asynchronous serial receiver, 8N1 (8E1 with RS232_RX_PARITY_EN),
// with a valid/ready byte output and frame-error / overrun pulses.
module rs232_rx #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef RS232_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RS232_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t     state_q, state_d;
  logic       rxd_meta, rxd_s;
  logic [7:0] presc;
  logic       tick;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;

  logic start_det, restart_ticks, sample_bit, stop_ok, fe_d;
  logic mid_tick, last_tick;
`ifdef RS232_RX_PARITY_EN
  logic par_bit, sample_par, pe_d;
`endif

  assign tick      = (presc == 8'(DIV - 1));
  assign mid_tick  = tick && (tick_cnt == 4'd7);
  assign last_tick = tick && (tick_cnt == 4'd15);
  assign busy      = (state_q != IDLE);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_d       = state_q;
    start_det     = 1'b0;
    restart_ticks = 1'b0;
    sample_bit    = 1'b0;
    stop_ok       = 1'b0;
    fe_d          = 1'b0;
`ifdef RS232_RX_PARITY_EN
    sample_par    = 1'b0;
    pe_d          = 1'b0;
`endif
    case (state_q)
      IDLE: if (!rxd_s) begin
        state_d   = START;
        start_det = 1'b1;
      end
      START: if (mid_tick) begin
        if (!rxd_s) begin
          state_d       = DATA;
          restart_ticks = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (last_tick) begin
        sample_bit = 1'b1;
`ifdef RS232_RX_PARITY_EN
        if (bit_idx == 3'd7) state_d = PARITY;
`else
        if (bit_idx == 3'd7) state_d = STOP;
`endif
      end
`ifdef RS232_RX_PARITY_EN
      PARITY: if (last_tick) begin
        sample_par = 1'b1;
        state_d    = STOP;
      end
`endif
      STOP: if (last_tick) begin
        if (!rxd_s) begin
          fe_d    = 1'b1;
          state_d = WAIT_HIGH;
        end else begin
          state_d = IDLE;
`ifdef RS232_RX_PARITY_EN
          // Framing is checked first, so a bad stop bit masks a bad parity bit.
          if (par_bit != ^shift) pe_d = 1'b1;
          else                   stop_ok = 1'b1;
`else
          stop_ok = 1'b1;
`endif
        end
      end
      WAIT_HIGH: if (rxd_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q   <= IDLE;
      rxd_meta  <= 1'b1;
      rxd_s     <= 1'b1;
      presc     <= '0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef RS232_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;

      if (start_det || tick) presc <= '0;
      else                   presc <= presc + 8'd1;

      if (start_det || restart_ticks) tick_cnt <= '0;
      else if (tick)                  tick_cnt <= tick_cnt + 4'd1;

      if (restart_ticks)   bit_idx <= '0;
      else if (sample_bit) bit_idx <= bit_idx + 3'd1;

      // A completed byte is only accepted if the holding register is free or being drained now.
      if (stop_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      overrun   <= stop_ok && rx_valid && !rx_ready;
      frame_err <= fe_d;
`ifdef RS232_RX_PARITY_EN
      if (sample_par) par_bit <= rxd_s;
      parity_err <= pe_d;
`endif
    end
  end

  // NOTE: the shift register is fully rewritten before every use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (sample_bit) shift[bit_idx] <= rxd_s;
  end

endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: directed frames into rs232_rx with a byte scoreboard; builds with or without
// RS232_RX_PARITY_EN.
module tb_rs232_rx;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst, rxd, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
`ifdef RS232_RX_PARITY_EN
  logic       parity_err;
`endif

  rs232_rx #(.DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
`ifdef RS232_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = 0;
  int   valid_cycles = 0, fe_cycles = 0, ov_cycles = 0, pe_cycles = 0;
  logic valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pulse counters plus scoreboard pop on every handshake.
  always @(negedge clk) begin
    if (rx_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = rx_valid;
    if (rx_valid)  valid_cycles++;
    if (frame_err) fe_cycles++;
    if (overrun)   ov_cycles++;
`ifdef RS232_RX_PARITY_EN
    if (parity_err) pe_cycles++;
`endif
    if (rx_valid && rx_ready) begin
      check("sb_byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int bit_times);
    rxd = v;
    wait_cycles(BIT * bit_times);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_lvl,
                            input int stop_bt);
    start_cyc = cyc;
    drive_bit(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 1);
`ifdef RS232_RX_PARITY_EN
    drive_bit(par, 1);
`else
    if (par) begin end
`endif
    drive_bit(stop_lvl, stop_bt);
  endtask

  int v0, f0, o0, p0, lat;

  initial begin
    rst = 1'b1; rxd = 1'b1; rx_ready = 1'b1;
    wait_cycles(3);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    wait_cycles(20);

    // Nominal byte with a ready consumer.
    v0 = valid_cycles; f0 = fe_cycles;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    wait_cycles(2 * BIT);
    lat = rise_cyc - start_cyc;
    check("a5_valid_one_cycle", 32'(valid_cycles - v0), 32'd1);
    check("a5_no_frame_err", 32'(fe_cycles - f0), 32'd0);
    check("a5_latency_in_window", 32'(lat >= 606 && lat <= 614), 32'd1);
    check("a5_valid_cleared", 32'(rx_valid), 32'd0);

    // Start-bit glitch of three ticks.
    v0 = valid_cycles; f0 = fe_cycles; o0 = ov_cycles;
    rxd = 1'b0;
    wait_cycles(12);
    check("glitch_busy_high", 32'(busy), 32'd1);
    rxd = 1'b1;
    for (int i = 0; i < 40 && busy; i++) wait_cycles(1);
    check("glitch_busy_dropped", 32'(busy), 32'd0);
    wait_cycles(BIT);
    check("glitch_no_valid", 32'(valid_cycles - v0), 32'd0);
    check("glitch_no_frame_err", 32'(fe_cycles - f0), 32'd0);
    check("glitch_no_overrun", 32'(ov_cycles - o0), 32'd0);

    // Stop bit held low for two bit-times (break-like).
    v0 = valid_cycles; f0 = fe_cycles;
    send_frame(8'h3C, ^8'h3C, 1'b0, 2);
    check("break_busy_while_low", 32'(busy), 32'd1);
    check("break_frame_err_single", 32'(fe_cycles - f0), 32'd1);
    rxd = 1'b1;
    wait_cycles(4);
    check("break_busy_released", 32'(busy), 32'd0);
    check("break_no_valid", 32'(valid_cycles - v0), 32'd0);
    wait_cycles(BIT);

    // Overrun: consumer stalled across two bytes.
    rx_ready = 1'b0;
    o0 = ov_cycles;
    exp_q.push_back(8'h11);
    send_frame(8'h11, ^8'h11, 1'b1, 1);
    wait_cycles(BIT);
    check("ovr_first_valid", 32'(rx_valid), 32'd1);
    send_frame(8'h22, ^8'h22, 1'b1, 1);
    wait_cycles(BIT);
    check("ovr_pulse_single", 32'(ov_cycles - o0), 32'd1);
    check("ovr_data_held", 32'(rx_data), 32'h11);
    check("ovr_valid_held", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
    check("ovr_valid_cleared", 32'(rx_valid), 32'd0);
    rx_ready = 1'b1;
    wait_cycles(BIT);

    // Reset in the middle of 0x55, line then idles before 0x0F.
    v0 = valid_cycles; f0 = fe_cycles; o0 = ov_cycles;
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 1); drive_bit(1'b0, 1); drive_bit(1'b1, 1); drive_bit(1'b0, 1);
    rxd = 1'b1;
    wait_cycles(20);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    check("rst_mid_busy_cleared", 32'(busy), 32'd0);
    wait_cycles(12 * BIT);
    check("rst_mid_no_valid", 32'(valid_cycles - v0), 32'd0);
    check("rst_mid_no_frame_err", 32'(fe_cycles - f0), 32'd0);
    check("rst_mid_no_overrun", 32'(ov_cycles - o0), 32'd0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, ^8'h0F, 1'b1, 1);
    wait_cycles(2 * BIT);
    check("rst_then_0f_valid", 32'(valid_cycles - v0), 32'd1);

`ifdef RS232_RX_PARITY_EN
    // Even parity: 0x07 needs a parity bit of 1.
    v0 = valid_cycles; p0 = pe_cycles; f0 = fe_cycles;
    send_frame(8'h07, 1'b0, 1'b1, 1);
    wait_cycles(2 * BIT);
    check("par_bad_pulse", 32'(pe_cycles - p0), 32'd1);
    check("par_bad_no_valid", 32'(valid_cycles - v0), 32'd0);
    check("par_bad_no_frame_err", 32'(fe_cycles - f0), 32'd0);
    p0 = pe_cycles;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1);
    wait_cycles(2 * BIT);
    check("par_good_no_pulse", 32'(pe_cycles - p0), 32'd0);
    check("par_good_valid", 32'(valid_cycles - v0), 32'd1);
`else
    p0 = pe_cycles;
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs232_rx.md
RS232_RX -- requirements
Module: rs232_rx

Interface
REQ-001 SHALL provide parameter DIV, default 4: clk cycles per oversample tick; legal range 1..255; 16 ticks per bit period.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide port rxd  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 SHALL provide port rx_data  output  8  last accepted received byte.
REQ-006 SHALL provide port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 SHALL provide port rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready are both high.
REQ-008 SHALL provide port frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL provide port overrun  output  1  one-cycle pulse when a completed byte is dropped.
REQ-010 SHALL provide port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer; all logic uses the synchronized value rxd_s only.
REQ-012 SHALL hold a tick prescaler counting 0..DIV-1 that emits a one-cycle tick on wrap; prescaler and a 4-bit tick counter clear on start detect.
REQ-013 SHALL use states IDLE, START, DATA, STOP, WAIT_HIGH (plus PARITY, see REQ-024).
REQ-014 IDLE: rxd_s==0 -> START on the next edge.
REQ-015 START: at tick 8, rxd_s==0 -> DATA with bit index 0 and tick counter cleared; rxd_s==1 -> IDLE as a glitch, with no outputs asserted.
REQ-016 DATA: sample rxd_s every 16 ticks into bit[index], LSB first; after bit 7 -> STOP.
REQ-017 STOP: sample at 16 ticks; 1 -> deliver byte (REQ-019), then IDLE; 0 -> frame_err pulse, byte discarded, then WAIT_HIGH.
REQ-018 WAIT_HIGH: stay until rxd_s==1, then IDLE; this covers the break condition.
REQ-019 Delivery: if rx_valid==0, or rx_valid and rx_ready in the same cycle, load rx_data and set rx_valid=1; otherwise keep the old rx_data and rx_valid, and pulse overrun.
REQ-020 rx_valid SHALL clear on the edge after a handshake cycle unless a delivery occurs in that same cycle; rx_data SHALL be stable while rx_valid is high.
REQ-021 Latency: rx_valid rises 2 + DIV*(8+16*9) +/- DIV clk cycles after the rxd falling edge.

Reset
REQ-022 With rst high on an edge: state=IDLE, synchronizer flops=1, counters=0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame; no valid or error output results from it; reception resumes on the next falling edge after rst deasserts.

Configuration
REQ-024 Macro RS232_RX_PARITY_EN defined: after DATA, enter PARITY, sample 1 bit at 16 ticks, then STOP; the frame is 8E1.
- Adds port parity_err  output  1: one-cycle pulse when the received parity bit != XOR of the data bits (even parity); byte discarded; STOP still sampled.
- Frame error takes precedence: only frame_err pulses if both fail.
REQ-025 Macro undefined: no PARITY state, no parity_err port, frame is 8N1.

Verification
REQ-026 DIV=4, send 0xA5 (64 clk per bit), rx_ready=1 -> rx_valid one cycle with rx_data=0xA5 within 2+608+/-4 cycles of the start edge; frame_err=0.
REQ-027 rxd low for 12 clk (3 ticks) then high -> returns to IDLE; rx_valid, frame_err and overrun stay 0; busy drops within 40 cycles.
REQ-028 Send 0x3C with stop bit driven 0 for 2 bit-times -> frame_err single pulse, rx_valid=0, busy high until rxd returns to 1.
REQ-029 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, overrun single pulse at the second stop; after rx_ready=1 for one cycle, rx_valid=0.
REQ-030 Assert rst for 1 cycle during bit 4 of 0x55, then send 0x0F -> only 0x0F is delivered.
REQ-031 With RS232_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; with parity bit 1 -> rx_data=0x07.
